// File: rtl/alu.sv
// rtl/alu.sv - registered single-cycle ALU with status flags
// Define ALU_EXT_OPS_EN to add OR (opcode 10) and XOR (opcode 11).
module alu #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           opcode,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BUS_WIDTH-1:0] y,
    output logic                 carry_out,
    output logic                 borrow,
    output logic                 zero,
    output logic                 parity,
    output logic                 invalid_op
);

    localparam logic [3:0] OP_ADD       = 4'd1;
    localparam logic [3:0] OP_ADD_CARRY = 4'd2;
    localparam logic [3:0] OP_SUB       = 4'd3;
    localparam logic [3:0] OP_INC       = 4'd4;
    localparam logic [3:0] OP_DEC       = 4'd5;
    localparam logic [3:0] OP_AND       = 4'd6;
    localparam logic [3:0] OP_NOT       = 4'd7;
    localparam logic [3:0] OP_ROL       = 4'd8;
    localparam logic [3:0] OP_ROR       = 4'd9;
`ifdef ALU_EXT_OPS_EN
    localparam logic [3:0] OP_OR        = 4'd10;
    localparam logic [3:0] OP_XOR       = 4'd11;
`endif

    localparam logic [BUS_WIDTH:0] ONE_EXT = {{BUS_WIDTH{1'b0}}, 1'b1};

    logic [BUS_WIDTH-1:0] y_d, y_q;
    logic                 carry_d, carry_q;
    logic                 borrow_d, borrow_q;
    logic                 zero_d, zero_q;
    logic                 parity_d, parity_q;
    logic                 invalid_d, invalid_q;

    logic [BUS_WIDTH:0]   sum_ext;
    logic [BUS_WIDTH:0]   diff_ext;
    logic [BUS_WIDTH:0]   cin_ext;

    // The (BUS_WIDTH+1)-bit sum/difference carries carry and borrow in its MSB.
    always_comb begin
        cin_ext  = {{BUS_WIDTH{1'b0}}, (opcode == OP_ADD_CARRY) ? carry_in : 1'b0};
        sum_ext  = {1'b0, a} + {1'b0, b} + cin_ext;
        diff_ext = {1'b0, a} - {1'b0, b};
    end

    always_comb begin
        y_d       = '0;
        carry_d   = 1'b0;
        borrow_d  = 1'b0;
        invalid_d = 1'b0;
        unique case (opcode)
            OP_ADD, OP_ADD_CARRY: begin
                y_d     = sum_ext[BUS_WIDTH-1:0];
                carry_d = sum_ext[BUS_WIDTH];
            end
            OP_SUB: begin
                y_d      = diff_ext[BUS_WIDTH-1:0];
                borrow_d = diff_ext[BUS_WIDTH];
            end
            OP_INC: begin
                y_d     = a + ONE_EXT[BUS_WIDTH-1:0];
                carry_d = &a;
            end
            OP_DEC: begin
                y_d      = a - ONE_EXT[BUS_WIDTH-1:0];
                borrow_d = ~|a;
            end
            OP_AND: y_d = a & b;
            OP_NOT: y_d = ~a;
            OP_ROL: y_d = {a[BUS_WIDTH-2:0], a[BUS_WIDTH-1]};
            OP_ROR: y_d = {a[0], a[BUS_WIDTH-1:1]};
`ifdef ALU_EXT_OPS_EN
            OP_OR:  y_d = a | b;
            OP_XOR: y_d = a ^ b;
`endif
            default: invalid_d = 1'b1;
        endcase
        zero_d   = ~|y_d;
        parity_d = ^y_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= '0;
            carry_q   <= 1'b0;
            borrow_q  <= 1'b0;
            zero_q    <= 1'b0;
            parity_q  <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            carry_q   <= carry_d;
            borrow_q  <= borrow_d;
            zero_q    <= zero_d;
            parity_q  <= parity_d;
            invalid_q <= invalid_d;
        end
    end

    assign y          = y_q;
    assign carry_out  = carry_q;
    assign borrow     = borrow_q;
    assign zero       = zero_q;
    assign parity     = parity_q;
    assign invalid_op = invalid_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for alu; expectations follow ALU_EXT_OPS_EN
module tb_alu;

    typedef struct packed {
        logic [7:0] y;
        logic       co;
        logic       bo;
        logic       z;
        logic       p;
        logic       inv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       carry_in = 1'b0;
    logic [7:0] y;
    logic       carry_out, borrow, zero, parity, invalid_op;

    int total = 0;
    int bad   = 0;

    exp_t  exp_q[$];
    string name_q[$];

    alu #(.BUS_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .a(a), .b(b), .carry_in(carry_in),
        .y(y), .carry_out(carry_out), .borrow(borrow), .zero(zero),
        .parity(parity), .invalid_op(invalid_op)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] yy, input logic co, input logic bo,
                                input logic z, input logic p, input logic inv);
        mk = '{y: yy, co: co, bo: bo, z: z, p: p, inv: inv};
    endfunction

    function automatic exp_t sample();
        sample = '{y: y, co: carry_out, bo: borrow, z: zero, p: parity, inv: invalid_op};
    endfunction

    task automatic check(input string nm, input exp_t act, input exp_t req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got y=%02h co=%b bo=%b z=%b p=%b inv=%b, expected y=%02h co=%b bo=%b z=%b p=%b inv=%b",
                     nm, act.y, act.co, act.bo, act.z, act.p, act.inv,
                     req.y, req.co, req.bo, req.z, req.p, req.inv);
        end
    endtask

    task automatic issue(input string nm, input logic [3:0] op, input logic [7:0] aa,
                         input logic [7:0] bb, input logic ci, input exp_t e);
        @(negedge clk);
        opcode   = op;
        a        = aa;
        b        = bb;
        carry_in = ci;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected results never observed, required 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // Monitor: each edge with pending stimulus retires one expectation.
    always @(posedge clk) begin
        if (!rst && exp_q.size() != 0) begin
            #1;
            check(name_q.pop_front(), sample(), exp_q.pop_front());
        end
    end

    exp_t e_op10, e_op11;

    initial begin
`ifdef ALU_EXT_OPS_EN
        e_op10 = mk(8'hFF, 0, 0, 0, 0, 0);
        e_op11 = mk(8'hCC, 0, 0, 0, 0, 0);
`else
        e_op10 = mk(8'h00, 0, 0, 1, 0, 1);
        e_op11 = mk(8'h00, 0, 0, 1, 0, 1);
`endif
        repeat (3) @(posedge clk);
        #1 check("reset_hold", sample(), mk(8'h00, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        issue("op0_invalid",  4'd0,  8'd0,   8'd0,   1'b0, mk(8'd0,   0, 0, 1, 0, 1));
        issue("add_9_33",     4'd1,  8'd9,   8'd33,  1'b0, mk(8'd42,  0, 0, 0, 1, 0));
        issue("add_ign_cin",  4'd1,  8'd9,   8'd33,  1'b1, mk(8'd42,  0, 0, 0, 1, 0));
        issue("addc_9_33_1",  4'd2,  8'd9,   8'd33,  1'b1, mk(8'd43,  0, 0, 0, 0, 0));
        issue("add_200_100",  4'd1,  8'd200, 8'd100, 1'b0, mk(8'd44,  1, 0, 0, 1, 0));
        issue("addc_255_0_1", 4'd2,  8'd255, 8'd0,   1'b1, mk(8'd0,   1, 0, 1, 0, 0));
        issue("sub_65_64",    4'd3,  8'd65,  8'd64,  1'b0, mk(8'd1,   0, 0, 0, 1, 0));
        issue("sub_65_66",    4'd3,  8'd65,  8'd66,  1'b0, mk(8'd255, 0, 1, 0, 0, 0));
        issue("sub_5_5",      4'd3,  8'd5,   8'd5,   1'b0, mk(8'd0,   0, 0, 1, 0, 0));
        issue("dec_0",        4'd5,  8'd0,   8'd7,   1'b1, mk(8'd255, 0, 1, 0, 0, 0));
        issue("dec_1",        4'd5,  8'd1,   8'd0,   1'b0, mk(8'd0,   0, 0, 1, 0, 0));
        issue("inc_233",      4'd4,  8'd233, 8'd9,   1'b1, mk(8'd234, 0, 0, 0, 1, 0));
        issue("inc_255",      4'd4,  8'd255, 8'd0,   1'b0, mk(8'd0,   1, 0, 1, 0, 0));
        issue("and_02_03",    4'd6,  8'h02,  8'h03,  1'b0, mk(8'h02,  0, 0, 0, 1, 0));
        issue("not_ff",       4'd7,  8'hFF,  8'h00,  1'b0, mk(8'h00,  0, 0, 1, 0, 0));
        issue("not_0f",       4'd7,  8'h0F,  8'h00,  1'b0, mk(8'hF0,  0, 0, 0, 0, 0));
        issue("rol_01",       4'd8,  8'h01,  8'h00,  1'b0, mk(8'h02,  0, 0, 0, 1, 0));
        issue("rol_80",       4'd8,  8'h80,  8'h00,  1'b0, mk(8'h01,  0, 0, 0, 1, 0));
        issue("ror_80",       4'd9,  8'h80,  8'h00,  1'b0, mk(8'h40,  0, 0, 0, 1, 0));
        issue("ror_01",       4'd9,  8'h01,  8'h00,  1'b0, mk(8'h80,  0, 0, 0, 1, 0));
        issue("op10_or",      4'd10, 8'hF0,  8'h0F,  1'b0, e_op10);
        issue("op11_xor",     4'd11, 8'hF0,  8'h3C,  1'b0, e_op11);
        issue("op15_invalid", 4'd15, 8'hF0,  8'h3C,  1'b1, mk(8'd0,   0, 0, 1, 0, 1));
        issue("op12_invalid", 4'd12, 8'h55,  8'hAA,  1'b0, mk(8'd0,   0, 0, 1, 0, 1));
        issue("add_before_rst", 4'd1, 8'd200, 8'd100, 1'b0, mk(8'd44, 1, 0, 0, 1, 0));
        drain();

        // Asynchronous reset mid-cycle must clear outputs without a clock edge.
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("async_reset", sample(), mk(8'h00, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        issue("post_rst_op0", 4'd0, 8'd3, 8'd4, 1'b0, mk(8'd0, 0, 0, 1, 0, 1));
        issue("post_rst_add", 4'd1, 8'd9, 8'd33, 1'b0, mk(8'd42, 0, 0, 0, 1, 0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Parameterised, single-cycle-latency registered arithmetic/logic unit.
- Operands `a`/`b` and a 4-bit `opcode` are sampled on each rising clock edge.
- Result `y` plus status flags (`carry_out`, `borrow`, `zero`, `parity`, `invalid_op`) are registered.
- Sits in a datapath as a stateless compute element; no handshake, one operation accepted every cycle.

Parameters:
- BUS_WIDTH, 8, operand/result width in bits; legal range ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- opcode  input  4  operation select
- a  input  BUS_WIDTH  operand A (unsigned)
- b  input  BUS_WIDTH  operand B (unsigned)
- carry_in  input  1  carry input; used only by ADD_CARRY
- y  output  BUS_WIDTH  registered result
- carry_out  output  1  registered carry flag
- borrow  output  1  registered borrow flag
- zero  output  1  registered, 1 when y == 0
- parity  output  1  registered, XOR of all y bits (1 = odd number of ones)
- invalid_op  output  1  registered, 1 when opcode unsupported

Behaviour:
- Reset (rst=1, asynchronous, no clock needed): y=0, carry_out=0, borrow=0, zero=0, parity=0, invalid_op=0. Held while rst=1.
- Latency: result and flags for inputs present at rising edge N appear after edge N and hold until edge N+1. Every edge computes a new result; no enable.
- Opcode map (all arithmetic unsigned, modulo 2^BUS_WIDTH):
  - 1 ADD: y=a+b; carry_out=bit BUS_WIDTH of the (BUS_WIDTH+1)-bit sum.
  - 2 ADD_CARRY: y=a+b+carry_in; carry_out as ADD.
  - 3 SUB: y=a-b; borrow=1 iff a<b.
  - 4 INC: y=a+1; carry_out=1 iff a=all-ones (wrap to 0). b and carry_in ignored.
  - 5 DEC: y=a-1; borrow=1 iff a=0 (wrap to all-ones).
  - 6 AND: y=a&b.
  - 7 NOT: y=~a.
  - 8 ROL: y={a[BUS_WIDTH-2:0], a[BUS_WIDTH-1]} (rotate left by 1).
  - 9 ROR: y={a[0], a[BUS_WIDTH-1:1]} (rotate right by 1).
  - 0 and 10–15: invalid. y=0, invalid_op=1.
- Flag rules:
  - carry_out is 0 for every opcode other than ADD, ADD_CARRY and INC.
  - borrow is 0 for every opcode other than SUB and DEC.
  - invalid_op is 0 for all supported opcodes.
  - zero and parity are derived from the next y value on every non-reset edge, including invalid opcodes (invalid → zero=1, parity=0).
- X/unknown inputs are not specially handled.
- Inputs may change arbitrarily between edges; only edge-sampled values matter.
- Deassertion of rst takes effect at the next edge, which loads a normal result.

Optional Feature:
- Macro ALU_EXT_OPS_EN.
- Defined:
  - opcode 10 OR: y=a|b.
  - opcode 11 XOR: y=a^b.
  - Both set carry_out=0, borrow=0, invalid_op=0.
  - Opcodes 0 and 12–15 remain invalid.
- Undefined: opcodes 10 and 11 are invalid (y=0, invalid_op=1), identical to the base map.

Test Plan (BUS_WIDTH=8, check outputs after the edge following stimulus):
- Reset: rst=1 asynchronously mid-cycle → all outputs 0 immediately. opcode=0 after release → y=0, invalid_op=1, zero=1.
- Add:
  - ADD a=9, b=33 → y=42, carry_out=0, parity=1.
  - ADD_CARRY a=9, b=33, carry_in=1 → y=43, parity=0.
  - ADD a=200, b=100 → y=44, carry_out=1.
- Subtract:
  - SUB 65−64 → y=1, borrow=0.
  - SUB 65−66 → y=255, borrow=1.
  - DEC a=0 → y=255, borrow=1.
  - INC a=233 → y=234, carry_out=0.
  - INC a=255 → y=0, carry_out=1, zero=1.
- Logic:
  - AND 0x02&0x03 → y=0x02.
  - NOT 0xFF → y=0x00, zero=1, parity=0.
- Rotate: ROL 0x01 → 0x02; ROL 0x80 → 0x01; ROR 0x80 → 0x40; ROR 0x01 → 0x80.
- Extension: opcode 11, a=0xF0, b=0x3C → with ALU_EXT_OPS_EN y=0xCC, invalid_op=0; without it y=0, invalid_op=1. Opcode 15 → invalid_op=1 in both builds.
